// File: rtl/vga_regs_pkg.sv
// Shared constants for the VGA register writer: bus widths, register map,
// power-on register values and the flush FSM state type.
package vga_regs_pkg;

    localparam int NUM_REGS = 13;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = $clog2(NUM_REGS);

    localparam int DINO_X     = 0;
    localparam int DINO_Y     = 1;
    localparam int JUMP_X     = 2;
    localparam int JUMP_Y     = 3;
    localparam int DUCK_X     = 4;
    localparam int DUCK_Y     = 5;
    localparam int CACTUS_X   = 6;
    localparam int CACTUS_Y   = 7;
    localparam int GODZILLA_X = 8;
    localparam int GODZILLA_Y = 9;
    localparam int SCORE      = 10;
    localparam int SCORE_X    = 11;
    localparam int SCORE_Y    = 12;

    // Cactus X and Godzilla Y are stored truncated to their 8-bit register fields.
    localparam logic [DATA_W-1:0] REG_DEFAULTS [NUM_REGS] = '{
        DATA_W'(100), DATA_W'(100),
        DATA_W'(200), DATA_W'(150),
        DATA_W'(300), DATA_W'(200),
        DATA_W'(500 & 'hFF), DATA_W'(100),
        DATA_W'(100), DATA_W'(260 & 'hFF),
        DATA_W'(0), DATA_W'(0), DATA_W'(0)
    };

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_e;

endpackage

// File: rtl/vga_reg_writer_if.sv
// Avalon-MM write-only bus between the register writer (master) and the
// display peripheral's register port (slave).
interface vga_reg_writer_if;
    import vga_regs_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;

    modport master (
        output address, chipselect, write, writedata,
        input  waitrequest
    );

    modport slave (
        input  address, chipselect, write, writedata,
        output waitrequest
    );

endinterface

// File: rtl/vga_reg_writer_lowest_set_idx.sv
// Lowest-set-bit priority encoder: returns the smallest index whose mask bit
// is set, with valid low when the mask is empty.
module lowest_set_idx #(
    parameter int W  = 13,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_reg_writer.sv
// Shadow register file for the display peripheral; once per frame it streams
// the changed registers over Avalon-MM in ascending address order.
module vga_reg_writer
    import vga_regs_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  upd_valid,
    input  logic [ADDR_W-1:0]     upd_addr,
    input  logic [DATA_W-1:0]     upd_data,
    vga_reg_writer_if.master      avm,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  bad_addr
);

    state_e                           state_q, state_d;
    logic [NUM_REGS-1:0]              dirty_q, dirty_d;
    logic [NUM_REGS-1:0]              pending_q, pending_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  shadow_q, shadow_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [DATA_W-1:0]                data_q, data_d;
    logic                             write_q, write_d;
    logic                             busy_q, busy_d;
    logic                             overrun_q, overrun_d;
    logic                             bad_addr_q, bad_addr_d;

    logic [NUM_REGS-1:0] pend_after, enc_mask;
    logic [IDX_W-1:0]    nxt_idx, acc_idx, upd_idx;
    logic                nxt_vld, accept, upd_ok;

    assign accept  = write_q && !avm.waitrequest;
    assign acc_idx = addr_q[IDX_W-1:0];
    assign upd_ok  = upd_valid && (upd_addr < ADDR_W'(NUM_REGS));
    assign upd_idx = upd_addr[IDX_W-1:0];

    always_comb begin
        pend_after = pending_q;
        if (accept) pend_after[acc_idx] = 1'b0;
    end

    // IDLE picks the first write from dirty; XFER picks the next from what remains pending.
    assign enc_mask = (state_q == IDLE) ? dirty_q : pend_after;

    lowest_set_idx #(.W(NUM_REGS), .IW(IDX_W)) u_enc (
        .mask  (enc_mask),
        .idx   (nxt_idx),
        .valid (nxt_vld)
    );

    always_comb begin
        state_d    = state_q;
        dirty_d    = dirty_q;
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        busy_d     = busy_q;
        overrun_d  = frame_start && busy_q;
        bad_addr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    busy_d    = 1'b1;
                    pending_d = dirty_q;
                    if (nxt_vld) begin
                        addr_d           = ADDR_W'(nxt_idx);
                        data_d           = shadow_q[nxt_idx];
                        write_d          = 1'b1;
                        dirty_d[nxt_idx] = 1'b0;
                        state_d          = XFER;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            XFER: begin
                if (accept) begin
                    pending_d = pend_after;
                    if (nxt_vld) begin
                        addr_d           = ADDR_W'(nxt_idx);
                        data_d           = shadow_q[nxt_idx];
                        dirty_d[nxt_idx] = 1'b0;
                    end else begin
                        write_d = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Dirty is cleared at launch, so any update arriving while the write is
        // stalled or in flight re-marks the register for the next frame.
        if (upd_valid) begin
            if (upd_ok) begin
                shadow_d[upd_idx] = upd_data;
                dirty_d[upd_idx]  = 1'b1;
            end else begin
                bad_addr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dirty_q    <= '1;
            pending_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= REG_DEFAULTS[i];
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            bad_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dirty_q    <= dirty_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign avm.address    = addr_q;
    assign avm.chipselect = write_q;
    assign avm.write      = write_q;
    assign avm.writedata  = data_q;
    assign busy           = busy_q;
    assign frame_done     = (state_q == DONE);
    assign overrun        = overrun_q;
    assign bad_addr       = bad_addr_q;

endmodule

// File: tb/tb_vga_reg_writer.sv
// Directed bench for vga_reg_writer: a vector table for the post-reset flush
// plus hand-written sequences for stalls, mid-flush updates, overrun and reset.
module tb_vga_reg_writer;
    import vga_regs_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_addr = '0;
    logic [DATA_W-1:0] upd_data = '0;
    logic              busy, frame_done, overrun, bad_addr;

    vga_reg_writer_if bus();

    vga_reg_writer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .upd_valid   (upd_valid),
        .upd_addr    (upd_addr),
        .upd_data    (upd_data),
        .avm         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .bad_addr    (bad_addr)
    );

    always #10 clk = ~clk;

    localparam int EXP_DEF [13] = '{100, 100, 200, 150, 300, 200, 244, 100, 100, 4, 0, 0, 0};

    typedef struct {
        logic        fs;
        logic        exp_wr;
        logic [8:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t        vt [15];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [8:0]  qa [$];
    logic [31:0] qd [$];

    // Log every completed transfer for the sequence checks.
    always @(posedge clk)
        if (!reset && bus.write && !bus.waitrequest) begin
            qa.push_back(bus.address);
            qd.push_back(bus.writedata);
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [8:0] a, input logic [31:0] d);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_data  = d;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic qclear();
        qa.delete();
        qd.delete();
    endtask

    // Pulses frame_start; lat = cycles from the strobe to frame_done (0 on timeout).
    task automatic run_frame(output int lat);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        lat = 1;
        while (!frame_done && lat < 200) begin
            step();
            lat++;
        end
        if (!frame_done) begin
            n_chk++;
            $display("FAIL frame_done_timeout: got 0, expected 1 within 200 cycles");
            lat = 0;
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        bus.waitrequest = 1'b0;

        for (int i = 0; i < 15; i++) begin
            vt[i].fs       = (i == 0);
            vt[i].exp_wr   = (i < 13);
            vt[i].exp_addr = (i < 13) ? 9'(i) : 9'd0;
            vt[i].exp_data = (i < 13) ? 32'(EXP_DEF[i]) : 32'd0;
            vt[i].exp_busy = (i < 14);
            vt[i].exp_done = (i == 13);
        end

        step();
        step();
        chk("rst_write", bus.write, 0);
        chk("rst_cs", bus.chipselect, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bad_addr", bad_addr, 0);
        reset = 1'b0;
        step();

        // Post-reset flush: all 13 defaults, back to back, done at T+14.
        for (int i = 0; i < 15; i++) begin
            frame_start = vt[i].fs;
            step();
            frame_start = 1'b0;
            chk($sformatf("t1_write[%0d]", i), bus.write, vt[i].exp_wr);
            chk($sformatf("t1_cs[%0d]", i), bus.chipselect, vt[i].exp_wr);
            if (vt[i].exp_wr) begin
                chk($sformatf("t1_addr[%0d]", i), bus.address, vt[i].exp_addr);
                chk($sformatf("t1_data[%0d]", i), bus.writedata, vt[i].exp_data);
            end
            chk($sformatf("t1_busy[%0d]", i), busy, vt[i].exp_busy);
            chk($sformatf("t1_done[%0d]", i), frame_done, vt[i].exp_done);
        end

        // Only changed registers, ascending order; then an empty frame.
        upd(10, 7);
        upd(2, 55);
        qclear();
        run_frame(lat);
        chk("t2_lat", lat, 3);
        chk("t2_count", qa.size(), 2);
        if (qa.size() == 2) begin
            chk("t2_a0", qa[0], 2);
            chk("t2_d0", qd[0], 55);
            chk("t2_a1", qa[1], 10);
            chk("t2_d1", qd[1], 7);
        end
        qclear();
        run_frame(lat);
        chk("t2_empty_lat", lat, 1);
        chk("t2_empty_count", qa.size(), 0);

        // Three stall cycles on the first write.
        upd(3, 'h33);
        upd(4, 'h44);
        bus.waitrequest = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.waitrequest = 1'b0;
            chk($sformatf("t3_hold_wr[%0d]", i), bus.write, 1);
            chk($sformatf("t3_hold_addr[%0d]", i), bus.address, 3);
            chk($sformatf("t3_hold_data[%0d]", i), bus.writedata, 'h33);
            step();
        end
        chk("t3_next_wr", bus.write, 1);
        chk("t3_next_addr", bus.address, 4);
        chk("t3_next_data", bus.writedata, 'h44);
        step();
        chk("t3_done", frame_done, 1);
        step();

        // Update to the register whose write is in flight.
        upd(5, 'h500);
        upd(6, 'h600);
        qclear();
        bus.waitrequest = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t4_addr", bus.address, 5);
        chk("t4_data", bus.writedata, 'h500);
        upd(5, 'h555);
        chk("t4_inflight_addr", bus.address, 5);
        chk("t4_inflight_data", bus.writedata, 'h500);
        bus.waitrequest = 1'b0;
        step();
        chk("t4_second_addr", bus.address, 6);
        chk("t4_second_data", bus.writedata, 'h600);
        step();
        chk("t4_done", frame_done, 1);
        step();
        chk("t4_count", qa.size(), 2);
        qclear();
        run_frame(lat);
        chk("t4_refl_lat", lat, 2);
        chk("t4_refl_count", qa.size(), 1);
        if (qa.size() == 1) begin
            chk("t4_refl_addr", qa[0], 5);
            chk("t4_refl_data", qd[0], 'h555);
        end

        // frame_start while busy, including the DONE cycle.
        upd(0, 11);
        upd(1, 12);
        qclear();
        frame_start = 1'b1;
        step();
        chk("t5_first_addr", bus.address, 0);
        step();
        frame_start = 1'b0;
        chk("t5_overrun", overrun, 1);
        chk("t5_second_addr", bus.address, 1);
        step();
        chk("t5_overrun_clr", overrun, 0);
        chk("t5_done", frame_done, 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t5_overrun_done", overrun, 1);
        chk("t5_idle_busy", busy, 0);
        step();
        chk("t5_no_restart", busy, 0);
        chk("t5_count", qa.size(), 2);

        // Illegal update address is dropped.
        upd(20, 'hDEAD);
        chk("t5_bad_addr", bad_addr, 1);
        step();
        chk("t5_bad_addr_clr", bad_addr, 0);
        qclear();
        run_frame(lat);
        chk("t5_bad_lat", lat, 1);
        chk("t5_bad_count", qa.size(), 0);

        // Reset in the middle of a stalled write.
        upd(8, 'h88);
        bus.waitrequest = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t6_pre_wr", bus.write, 1);
        chk("t6_pre_addr", bus.address, 8);
        reset = 1'b1;
        step();
        chk("t6_rst_wr", bus.write, 0);
        chk("t6_rst_cs", bus.chipselect, 0);
        chk("t6_rst_busy", busy, 0);
        reset = 1'b0;
        bus.waitrequest = 1'b0;
        step();
        qclear();
        run_frame(lat);
        chk("t6_lat", lat, 14);
        chk("t6_count", qa.size(), 13);
        for (int i = 0; i < qa.size() && i < 13; i++) begin
            chk($sformatf("t6_addr[%0d]", i), qa[i], i);
            chk($sformatf("t6_data[%0d]", i), qd[i], EXP_DEF[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
